// File: rtl/clock_switch_seq_if.sv
// Request handshake between a switch controller and clock_switch_seq.
// The master issues source/enable requests; the slave raises ready while idle.
interface clock_switch_seq_if #(
  parameter int SEL_W = 1,
  parameter int N_OUT = 2
);
  logic             I_req_valid;
  logic [SEL_W-1:0] I_req_src;
  logic [N_OUT-1:0] I_req_oe;
  logic             O_req_ready;

  modport master (
    output I_req_valid,
    output I_req_src,
    output I_req_oe,
    input  O_req_ready
  );

  modport slave (
    input  I_req_valid,
    input  I_req_src,
    input  I_req_oe,
    output O_req_ready
  );
endinterface

// File: rtl/clock_switch_seq.sv
// Safe switch sequencer for the crypto-clock source mux: gate the outputs, wait,
// move the select, let the new source settle, then re-enable the requested outputs.
module clock_switch_seq #(
  parameter int N_SRC      = 2,
  parameter int SEL_W      = 1,
  parameter int N_OUT      = 2,
  parameter int GUARD_CYC  = 4,
  parameter int SETTLE_CYC = 16
) (
  input  logic               usb_clk,
  input  logic               I_reset,
  clock_switch_seq_if.slave  req,
  input  logic [N_SRC-1:0]   I_src_ok,
  output logic [SEL_W-1:0]   O_src_sel,
  output logic [N_OUT-1:0]   O_clkout_en,
  output logic               O_busy,
  output logic               O_done,
  output logic               O_err,
  output logic [7:0]         O_switch_count
);

  localparam int MAX_CYC = (GUARD_CYC > SETTLE_CYC) ? GUARD_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int N_IDX   = 1 << SEL_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [N_OUT-1:0] en_q, en_d;
  logic [N_OUT-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [N_IDX-1:0] ok_ext;

  // Health flags padded to the full index range so an out-of-range source reads as unhealthy.
  always_comb begin
    ok_ext = '0;
    ok_ext[N_SRC-1:0] = I_src_ok;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    en_d    = en_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.I_req_valid) begin
          err_d  = 1'b0;
          tgt_d  = req.I_req_src;
          mask_d = req.I_req_oe;
          if (!ok_ext[req.I_req_src]) begin
            err_d = 1'b1;
          end else if (req.I_req_src == sel_q) begin
            en_d   = req.I_req_oe;
            done_d = 1'b1;
          end else begin
            en_d    = '0;
            cnt_d   = CNT_W'(GUARD_CYC - 1);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // A target that goes unhealthy aborts before any countdown transition.
        if (!ok_ext[tgt_q]) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          sel_d   = tgt_q;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (!ok_ext[tgt_q]) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          en_d    = mask_q;
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge usb_clk) begin
    if (I_reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      tgt_q   <= '0;
      en_q    <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      en_q    <= en_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req.O_req_ready = (state_q == IDLE);
  assign O_src_sel       = sel_q;
  assign O_clkout_en     = en_q;
  assign O_busy          = busy_q;
  assign O_done          = done_q;
  assign O_err           = err_q;
  assign O_switch_count  = count_q;

endmodule
